// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for three GPR writers (ALU, LSU, MDU) in front of the
// register file, with a per-register busy scoreboard and sticky error flag.
//
// Ports:
//   clk_i, rst_i             clock, async active-low reset
//   wb_valid_i/rd_i/data_i   per-requester writeback request (k = 0 ALU, 1 LSU, 2 MDU)
//   wb_ready_o               one-hot grant, combinational
//   issue_valid_i/rd_i       destination reservation from issue
//   Rd_o/Rd_data_o/Rd_wen_o  registered register-file write port
//   busy_o                   scoreboard of registers with a pending write
//   err_o                    sticky: write to a register that was not busy
module gpr_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [2:0]          wb_valid_i,
    input  logic [14:0]         wb_rd_i,
    input  logic [3*DATA_W-1:0] wb_data_i,
    output logic [2:0]          wb_ready_o,
    input  logic                issue_valid_i,
    input  logic [4:0]          issue_rd_i,
    output logic [4:0]          Rd_o,
    output logic [DATA_W-1:0]   Rd_data_o,
    output logic                Rd_wen_o,
    output logic [31:0]         busy_o,
    output logic                err_o
);

    logic [1:0]        ptr_q, ptr_d;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] data_q;
    logic              wen_q;
    logic [31:0]       busy_q, busy_d;
    logic              err_q, err_d;

    logic [4:0]        rd_a   [3];
    logic [DATA_W-1:0] data_a [3];

    logic [2:0]        gnt;
    logic [1:0]        gidx;
    logic [1:0]        cand;
    logic              found;
    logic              acc;
    logic [4:0]        g_rd;
    logic [DATA_W-1:0] g_data;

    for (genvar k = 0; k < 3; k++) begin : g_unpack
        assign rd_a[k]   = wb_rd_i[5*k +: 5];
        assign data_a[k] = wb_data_i[DATA_W*k +: DATA_W];
    end

    // Pointer only ever holds 0..2; treat 3 like 2 so it wraps to 0.
    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        cand  = ptr_q;
        found = 1'b0;
        if (ARB_MODE == 1) begin
            if (wb_valid_i[0]) begin
                gnt  = 3'b001;
                gidx = 2'd0;
            end else if (wb_valid_i[1]) begin
                gnt  = 3'b010;
                gidx = 2'd1;
            end else if (wb_valid_i[2]) begin
                gnt  = 3'b100;
                gidx = 2'd2;
            end
        end else begin
            // Search starts just after the last granted requester.
            for (int i = 0; i < 3; i++) begin
                cand = nxt(cand);
                if (!found && wb_valid_i[cand]) begin
                    found     = 1'b1;
                    gidx      = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
        if (!rst_i) begin
            gnt = '0;
        end
    end

    assign wb_ready_o = gnt;
    assign acc        = |gnt;
    assign g_rd       = rd_a[gidx];
    assign g_data     = data_a[gidx];
    assign ptr_d      = acc ? gidx : ptr_q;

    // A same-cycle issue to the register being retired must win.
    always_comb begin
        busy_d = busy_q;
        if (acc && g_rd != 5'd0) begin
            busy_d[g_rd] = 1'b0;
        end
        if (issue_valid_i && issue_rd_i != 5'd0) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign err_d = err_q | (acc && g_rd != 5'd0 && !busy_q[g_rd]);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q  <= 2'd2;
            rd_q   <= '0;
            data_q <= '0;
            wen_q  <= 1'b0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            wen_q  <= acc && g_rd != 5'd0;
            if (acc) begin
                rd_q   <= g_rd;
                data_q <= g_data;
            end
        end
    end

    assign Rd_o      = rd_q;
    assign Rd_data_o = data_q;
    assign Rd_wen_o  = wen_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: table of single-cycle vectors on a
// round-robin instance plus hand sequences for async reset and fixed priority.
module tb_gpr_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   wb_valid;
    logic [14:0]  wb_rd;
    logic [95:0]  wb_data;
    logic         issue_v;
    logic [4:0]   issue_rd;

    logic [2:0]   rdy0, rdy1;
    logic [4:0]   rdq0, rdq1;
    logic [31:0]  dat0, dat1;
    logic         wen0, wen1;
    logic [31:0]  busy0, busy1;
    logic         err0, err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.DATA_W(32), .ARB_MODE(0)) u_rr (
        .clk_i(clk), .rst_i(rst_n),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .wb_ready_o(rdy0),
        .issue_valid_i(issue_v), .issue_rd_i(issue_rd),
        .Rd_o(rdq0), .Rd_data_o(dat0), .Rd_wen_o(wen0),
        .busy_o(busy0), .err_o(err0)
    );

    gpr_wb_arbiter #(.DATA_W(32), .ARB_MODE(1)) u_fp (
        .clk_i(clk), .rst_i(rst_n),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .wb_ready_o(rdy1),
        .issue_valid_i(issue_v), .issue_rd_i(issue_rd),
        .Rd_o(rdq1), .Rd_data_o(dat1), .Rd_wen_o(wen1),
        .busy_o(busy1), .err_o(err1)
    );

    typedef struct packed {
        logic        rst;
        logic [2:0]  v;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] d0, d1, d2;
        logic        iv;
        logic [4:0]  ird;
        logic [2:0]  rdy;
        logic        wen;
        logic        ck;
        logic [4:0]  ord;
        logic [31:0] od;
        logic [31:0] busy;
        logic        err;
    } vec_t;

    localparam int N = 20;
    vec_t tbl [N];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wb_valid = '0;
        issue_v  = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [14:0] rd,
                         input logic [95:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    initial begin
        vec_t t;
        // rst v rd0 rd1 rd2 d0 d1 d2 iv ird | rdy wen ck ord od busy err
        tbl[0]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5,
                    3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h20, 1'b0};
        tbl[1]  = '{1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 5'd0,
                    3'b001, 1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7,
                    3'b000, 1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 32'h80, 1'b0};
        tbl[3]  = '{1'b0, 3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h11117777, 32'h0, 1'b1, 5'd7,
                    3'b010, 1'b1, 1'b1, 5'd7, 32'h11117777, 32'h80, 1'b0};
        tbl[4]  = '{1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1,
                    3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h2, 1'b0};
        tbl[5]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd2,
                    3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h6, 1'b0};
        tbl[6]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd3,
                    3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 32'hE, 1'b0};
        tbl[7]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd4,
                    3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h1E, 1'b0};
        tbl[8]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5,
                    3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h3E, 1'b0};
        tbl[9]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd6,
                    3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 32'h7E, 1'b0};
        tbl[10] = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h201, 32'h302, 1'b0, 5'd0,
                    3'b001, 1'b1, 1'b1, 5'd1, 32'h100, 32'h7C, 1'b0};
        tbl[11] = '{1'b0, 3'b111, 5'd4, 5'd2, 5'd3, 32'h400, 32'h201, 32'h302, 1'b0, 5'd0,
                    3'b010, 1'b1, 1'b1, 5'd2, 32'h201, 32'h78, 1'b0};
        tbl[12] = '{1'b0, 3'b111, 5'd4, 5'd5, 5'd3, 32'h400, 32'h501, 32'h302, 1'b0, 5'd0,
                    3'b100, 1'b1, 1'b1, 5'd3, 32'h302, 32'h70, 1'b0};
        tbl[13] = '{1'b0, 3'b111, 5'd4, 5'd5, 5'd6, 32'h400, 32'h501, 32'h602, 1'b0, 5'd0,
                    3'b001, 1'b1, 1'b1, 5'd4, 32'h400, 32'h60, 1'b0};
        tbl[14] = '{1'b0, 3'b111, 5'd4, 5'd5, 5'd6, 32'h400, 32'h501, 32'h602, 1'b0, 5'd0,
                    3'b010, 1'b1, 1'b1, 5'd5, 32'h501, 32'h40, 1'b0};
        tbl[15] = '{1'b0, 3'b111, 5'd4, 5'd5, 5'd6, 32'h400, 32'h501, 32'h602, 1'b0, 5'd0,
                    3'b100, 1'b1, 1'b1, 5'd6, 32'h602, 32'h0, 1'b0};
        tbl[16] = '{1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 5'd0,
                    3'b001, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0};
        tbl[17] = '{1'b0, 3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0, 1'b0, 5'd0,
                    3'b010, 1'b1, 1'b1, 5'd9, 32'h99, 32'h0, 1'b1};
        tbl[18] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,
                    3'b000, 1'b0, 1'b1, 5'd9, 32'h99, 32'h0, 1'b1};
        tbl[19] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0,
                    3'b000, 1'b0, 1'b1, 5'd9, 32'h99, 32'h0, 1'b1};

        // Reset state is visible before any clock edge; ready stays low.
        rst_n    = 1'b1;
        issue_v  = 1'b0;
        issue_rd = '0;
        drive(3'b111, {5'd3, 5'd2, 5'd1}, '0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst rdy", 64'(rdy0), 64'(3'b000));
        chk("rst wen", 64'(wen0), 64'(1'b0));
        chk("rst rd", 64'(rdq0), 64'(5'd0));
        chk("rst data", 64'(dat0), 64'(32'h0));
        chk("rst busy", 64'(busy0), 64'(32'h0));
        chk("rst err", 64'(err0), 64'(1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive('0, '0, '0);

        for (int i = 0; i < N; i++) begin
            t = tbl[i];
            if (t.rst) do_reset();
            drive(t.v, {t.rd2, t.rd1, t.rd0}, {t.d2, t.d1, t.d0});
            issue_v  = t.iv;
            issue_rd = t.ird;
            #1;
            chk($sformatf("v%0d rdy", i), 64'(rdy0), 64'(t.rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wen", i), 64'(wen0), 64'(t.wen));
            if (t.ck) begin
                chk($sformatf("v%0d rd", i), 64'(rdq0), 64'(t.ord));
                chk($sformatf("v%0d data", i), 64'(dat0), 64'(t.od));
            end
            chk($sformatf("v%0d busy", i), 64'(busy0), 64'(t.busy));
            chk($sformatf("v%0d err", i), 64'(err0), 64'(t.err));
        end

        // Mid-cycle reset with a write on the port and requests pending.
        drive(3'b001, {5'd0, 5'd0, 5'd10}, {64'h0, 32'hAB});
        issue_v  = 1'b1;
        issue_rd = 5'd10;
        #1;
        chk("mr rdy0", 64'(rdy0), 64'(3'b001));
        @(posedge clk);
        #1;
        issue_v = 1'b0;
        chk("mr wen", 64'(wen0), 64'(1'b1));
        chk("mr busy", 64'(busy0), 64'(32'h400));
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        #1;
        chk("mr rdy1", 64'(rdy0), 64'(3'b010));
        rst_n = 1'b0;
        #1;
        chk("mr rst wen", 64'(wen0), 64'(1'b0));
        chk("mr rst rd", 64'(rdq0), 64'(5'd0));
        chk("mr rst data", 64'(dat0), 64'(32'h0));
        chk("mr rst busy", 64'(busy0), 64'(32'h0));
        chk("mr rst err", 64'(err0), 64'(1'b0));
        chk("mr rst rdy", 64'(rdy0), 64'(3'b000));
        rst_n = 1'b1;
        #1;
        chk("mr rel rdy", 64'(rdy0), 64'(3'b001));
        @(posedge clk);
        #1;
        chk("mr rel wen", 64'(wen0), 64'(1'b1));
        chk("mr rel rd", 64'(rdq0), 64'(5'd1));

        // Fixed priority; accepted requesters drop out.
        do_reset();
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        #1;
        chk("fp c1 rdy", 64'(rdy1), 64'(3'b001));
        @(posedge clk);
        #1;
        chk("fp c1 rd", 64'(rdq1), 64'(5'd1));
        chk("fp c1 wen", 64'(wen1), 64'(1'b1));
        drive(3'b110, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        #1;
        chk("fp c2 rdy", 64'(rdy1), 64'(3'b010));
        @(posedge clk);
        #1;
        chk("fp c2 rd", 64'(rdq1), 64'(5'd2));
        chk("fp c2 data", 64'(dat1), 64'(32'h22));
        drive(3'b100, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        #1;
        chk("fp c3 rdy", 64'(rdy1), 64'(3'b100));
        @(posedge clk);
        #1;
        chk("fp c3 rd", 64'(rdq1), 64'(5'd3));
        drive(3'b001, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        @(posedge clk);
        #1;
        // Just granted 0: fixed priority grants 0 again, round-robin moves to 1.
        drive(3'b011, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        #1;
        chk("fp c5 rdy", 64'(rdy1), 64'(3'b001));
        chk("rr c5 rdy", 64'(rdy0), 64'(3'b010));
        @(posedge clk);
        #1;
        drive('0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
